// File: rtl/poly_inverse.sv
// poly_inverse: bisection inverse of a cubic over a 3-cycle Horner engine.
// Define POLY_INV_DESC_EN to add the `descending` search-mode input.
module poly_inverse #(
  parameter logic signed [11:0] X_MIN = 12'sh800,
  parameter logic signed [11:0] X_MAX = 12'sh7FF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [11:0] y_target,
  input  logic [11:0] param_in0,
  input  logic [11:0] param_in1,
  input  logic [11:0] param_in2,
  input  logic [11:0] param_in3,
`ifdef POLY_INV_DESC_EN
  input  logic        descending,
`endif
  output logic        busy,
  output logic        done,
  output logic [11:0] x_out,
  output logic        found,
  output logic        fail
);

  if (X_MIN > X_MAX) begin : g_range_err
    $error("poly_inverse: X_MIN must not exceed X_MAX");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_SEARCH,
    S_FINAL,
    S_DONE
  } state_t;

  state_t             r_state;
  state_t             w_state_nx;
  logic [1:0]         r_step;
  logic signed [11:0] r_lo;
  logic signed [11:0] r_hi;
  logic [11:0]        r_y;
  logic [11:0]        r_p0;
  logic [11:0]        r_p1;
  logic [11:0]        r_p2;
  logic [11:0]        r_p3;
  logic signed [47:0] r_acc;
  logic [11:0]        r_x_out;
  logic               r_found;
  logic               r_fail;
`ifdef POLY_INV_DESC_EN
  logic               r_desc;
`endif

  logic               w_last;
  logic signed [11:0] w_mid;
  logic signed [11:0] w_x;
  logic signed [47:0] w_x48;
  logic signed [47:0] w_acc_in;
  logic [11:0]        w_coef;
  logic signed [47:0] w_coef48;
  logic signed [47:0] w_sum;
  logic signed [47:0] w_y48;
  logic               w_ok;
  logic               w_eq;
  logic signed [11:0] w_lo_n;
  logic signed [11:0] w_hi_n;

  assign w_last = (r_step == 2'd2);
  // 13-bit sum then arithmetic shift gives floor((lo+hi)/2)
  assign w_mid  = 12'(($signed({r_lo[11], r_lo})
                     + $signed({r_hi[11], r_hi})) >>> 1);

  always_comb begin
    w_x = r_lo;
    if (r_state == S_CHECK)
      w_x = r_hi;
    else if (r_state == S_SEARCH)
      w_x = w_mid;
  end

  always_comb begin
    w_coef = r_p0;
    if (r_step == 2'd0)
      w_coef = r_p2;
    else if (r_step == 2'd1)
      w_coef = r_p1;
  end

  // Magnitudes stay below 2^45, so 48-bit products are exact
  assign w_x48    = {{36{w_x[11]}}, w_x};
  assign w_coef48 = {{36{w_coef[11]}}, w_coef};
  assign w_y48    = {{36{r_y[11]}}, r_y};
  assign w_acc_in = (r_step == 2'd0) ?
                    {{36{r_p3[11]}}, r_p3} : r_acc;
  assign w_sum    = w_acc_in * w_x48 + w_coef48;
  assign w_eq     = (w_sum == w_y48);

`ifdef POLY_INV_DESC_EN
  assign w_ok = r_desc ? (w_sum <= w_y48)
                       : (w_sum >= w_y48);
`else
  assign w_ok = (w_sum >= w_y48);
`endif

  assign w_lo_n = w_ok ? r_lo  : w_mid + 12'sd1;
  assign w_hi_n = w_ok ? w_mid : r_hi;

  always_ff @(posedge clock) begin
    if (reset)
      r_state <= S_IDLE;
    else
      r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    busy       = (r_state != S_IDLE);
    done       = (r_state == S_DONE);
    unique case (r_state)
      S_IDLE:
        if (start) w_state_nx = S_CHECK;
      S_CHECK:
        if (w_last) begin
          if (!w_ok)
            w_state_nx = S_DONE;
          else if (r_lo == r_hi)
            w_state_nx = S_FINAL;
          else
            w_state_nx = S_SEARCH;
        end
      S_SEARCH:
        if (w_last && (w_lo_n == w_hi_n))
          w_state_nx = S_FINAL;
      S_FINAL:
        if (w_last) w_state_nx = S_DONE;
      S_DONE:
        w_state_nx = S_IDLE;
      default:
        w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_step  <= 2'd0;
      r_lo    <= '0;
      r_hi    <= '0;
      r_y     <= '0;
      r_p0    <= '0;
      r_p1    <= '0;
      r_p2    <= '0;
      r_p3    <= '0;
      r_acc   <= '0;
      r_x_out <= '0;
      r_found <= 1'b0;
      r_fail  <= 1'b0;
`ifdef POLY_INV_DESC_EN
      r_desc  <= 1'b0;
`endif
    end else begin
      unique case (r_state)
        S_IDLE:
          if (start) begin
            r_y     <= y_target;
            r_p0    <= param_in0;
            r_p1    <= param_in1;
            r_p2    <= param_in2;
            r_p3    <= param_in3;
            r_lo    <= X_MIN;
            r_hi    <= X_MAX;
            r_step  <= 2'd0;
            r_x_out <= '0;
            r_found <= 1'b0;
            r_fail  <= 1'b0;
`ifdef POLY_INV_DESC_EN
            r_desc  <= descending;
`endif
          end
        S_CHECK, S_SEARCH, S_FINAL: begin
          r_acc  <= w_sum;
          r_step <= w_last ? 2'd0 : r_step + 2'd1;
          if (w_last) begin
            if (r_state == S_CHECK && !w_ok) begin
              r_fail  <= 1'b1;
              r_x_out <= X_MAX;
            end
            if (r_state == S_SEARCH) begin
              r_lo <= w_lo_n;
              r_hi <= w_hi_n;
            end
            if (r_state == S_FINAL) begin
              r_x_out <= r_lo;
              r_found <= w_eq;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign x_out = r_x_out;
  assign found = r_found;
  assign fail  = r_fail;

endmodule

// File: tb/tb_poly_inverse.sv
// tb_poly_inverse: random + directed checks of poly_inverse against
// an exhaustive-scan reference model on three search ranges.
module tb_poly_inverse;

  logic        clock = 1'b0;
  logic        reset;
  logic [11:0] yt, p0, p1, p2, p3;
`ifdef POLY_INV_DESC_EN
  logic        desc_s;
`endif
  logic        st  [3];
  logic        bz  [3];
  logic        dn  [3];
  logic        fnd [3];
  logic        fl  [3];
  logic [11:0] xo  [3];

  int xlo [3] = '{-2048, -10, 7};
  int xhi [3] = '{2047, 10, 7};

  int n_checks = 0;
  int n_errors = 0;

  always #5 clock = ~clock;

  poly_inverse #(.X_MIN(12'sh800), .X_MAX(12'sh7FF)) u_full (
    .clock(clock), .reset(reset), .start(st[0]),
    .y_target(yt), .param_in0(p0), .param_in1(p1),
    .param_in2(p2), .param_in3(p3),
`ifdef POLY_INV_DESC_EN
    .descending(desc_s),
`endif
    .busy(bz[0]), .done(dn[0]), .x_out(xo[0]),
    .found(fnd[0]), .fail(fl[0]));

  poly_inverse #(.X_MIN(-12'sd10), .X_MAX(12'sd10)) u_small (
    .clock(clock), .reset(reset), .start(st[1]),
    .y_target(yt), .param_in0(p0), .param_in1(p1),
    .param_in2(p2), .param_in3(p3),
`ifdef POLY_INV_DESC_EN
    .descending(desc_s),
`endif
    .busy(bz[1]), .done(dn[1]), .x_out(xo[1]),
    .found(fnd[1]), .fail(fl[1]));

  poly_inverse #(.X_MIN(12'sd7), .X_MAX(12'sd7)) u_deg (
    .clock(clock), .reset(reset), .start(st[2]),
    .y_target(yt), .param_in0(p0), .param_in1(p1),
    .param_in2(p2), .param_in3(p3),
`ifdef POLY_INV_DESC_EN
    .descending(desc_s),
`endif
    .busy(bz[2]), .done(dn[2]), .x_out(xo[2]),
    .found(fnd[2]), .fail(fl[2]));

  task automatic check(input string tag,
                       input longint got,
                       input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint peval(longint c0, c1, c2, c3, x);
    return c0 + c1 * x + c2 * x * x + c3 * x * x * x;
  endfunction

  // Smallest x in range meeting the target condition, by exhaustive scan
  task automatic model(input int lo, hi,
                       input int c0, c1, c2, c3, y,
                       input bit desc,
                       output bit ef, output int ex,
                       output bit efd);
    longint v;
    ef = 1'b1; ex = hi; efd = 1'b0;
    for (int x = lo; x <= hi; x++) begin
      v = peval(c0, c1, c2, c3, x);
      if (desc ? (v <= y) : (v >= y)) begin
        ef = 1'b0; ex = x; efd = (v == y);
        break;
      end
    end
  endtask

  task automatic run(input string nm, input int k,
                     input int c0, c1, c2, c3, y,
                     input bit desc, input bit glitch);
    bit ef, efd, seen, bok;
    int ex, lat, cyc;
    model(xlo[k], xhi[k], c0, c1, c2, c3, y, desc, ef, ex, efd);
    if (ef)          lat = 4;
    else if (k == 0) lat = 43;
    else if (k == 2) lat = 7;
    else             lat = -1;
    p0 = 12'(c0); p1 = 12'(c1); p2 = 12'(c2); p3 = 12'(c3);
    yt = 12'(y);
`ifdef POLY_INV_DESC_EN
    desc_s = desc;
`endif
    st[k] = 1'b1;
    @(posedge clock); #1;
    st[k] = 1'b0;
    cyc = 1; seen = 1'b0; bok = 1'b1;
    while (cyc <= 200) begin
      if (bz[k] !== 1'b1) bok = 1'b0;
      if (dn[k] === 1'b1) begin
        seen = 1'b1;
        break;
      end
      if (glitch && (cyc == 5 || cyc == 20)) begin
        st[k] = 1'b1; yt = ~12'(y);
      end else begin
        st[k] = 1'b0; yt = 12'(y);
      end
      @(posedge clock); #1;
      cyc++;
    end
    st[k] = 1'b0; yt = 12'(y);
    check({nm, "/done_seen"}, seen, 1);
    if (lat >= 0)
      check({nm, "/latency"}, cyc, lat);
    else
      check({nm, "/latency_rng"}, (cyc == 19 || cyc == 22), 1);
    check({nm, "/busy"}, bok, 1);
    check({nm, "/x_out"}, $signed(xo[k]), ex);
    check({nm, "/found"}, fnd[k], efd);
    check({nm, "/fail"}, fl[k], ef);
    @(posedge clock); #1;
    check({nm, "/idle"}, {bz[k], dn[k]}, 0);
    check({nm, "/hold"}, $signed(xo[k]), ex);
  endtask

  // Non-decreasing cubic: p3,p1 >= 0 and p2^2 <= 3*p1*p3
  task automatic rand_poly(output int c0, c1, c2, c3);
    int kk;
    c3 = int'($urandom_range(0, 3));
    c1 = int'($urandom_range(0, 40));
    kk = 0;
    while ((kk + 1) * (kk + 1) <= 3 * c1 * c3) kk++;
    c2 = int'($urandom_range(0, 2 * kk)) - kk;
    c0 = int'($urandom_range(0, 4095)) - 2048;
  endtask

  initial begin
    int c0, c1, c2, c3, y, nd, cyc;
    for (int i = 0; i < 3; i++) st[i] = 1'b0;
    yt = '0; p0 = '0; p1 = '0; p2 = '0; p3 = '0;
`ifdef POLY_INV_DESC_EN
    desc_s = 1'b0;
`endif
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check("rst/busy", bz[0], 0);
    check("rst/done", dn[0], 0);
    check("rst/x_out", xo[0], 0);
    check("rst/found", fnd[0], 0);
    check("rst/fail", fl[0], 0);
    reset = 1'b0;
    @(posedge clock); #1;

    run("lin100", 0, 0, 1, 0, 0, 100, 1'b0, 1'b1);
    run("cube27", 0, 0, 0, 0, 1, 27, 1'b0, 1'b0);
    run("cube30", 0, 0, 0, 0, 1, 30, 1'b0, 1'b0);
    run("lin_top", 0, 0, 1, 0, 0, 2047, 1'b0, 1'b0);
    run("const5", 0, 5, 0, 0, 0, -5, 1'b0, 1'b0);
    run("lin_bot", 0, 0, 1, 0, 0, -2048, 1'b0, 1'b0);
    run("fail", 0, -1, 1, 0, 0, 2047, 1'b0, 1'b0);
    run("sm_lin3", 1, 0, 1, 0, 0, 3, 1'b0, 1'b0);
    run("sm_fail", 1, 0, 1, 0, 0, 50, 1'b0, 1'b0);
    run("deg_eq", 2, 0, 1, 0, 0, 7, 1'b0, 1'b0);
    run("deg_lt", 2, 0, 1, 0, 0, 3, 1'b0, 1'b0);
    run("deg_fail", 2, 0, 1, 0, 0, 8, 1'b0, 1'b0);

    // Reset in cycle 20 of a search aborts it without a done pulse
    p0 = '0; p1 = 12'd1; p2 = '0; p3 = '0; yt = 12'd100;
    st[0] = 1'b1;
    @(posedge clock); #1;
    st[0] = 1'b0;
    cyc = 1;
    while (cyc < 20) begin
      @(posedge clock); #1;
      cyc++;
    end
    reset = 1'b1;
    @(posedge clock); #1;
    check("abort/busy", bz[0], 0);
    check("abort/done", dn[0], 0);
    check("abort/x_out", xo[0], 0);
    check("abort/found", fnd[0], 0);
    check("abort/fail", fl[0], 0);
    reset = 1'b0;
    nd = 0;
    repeat (60) begin
      @(posedge clock); #1;
      if (dn[0] === 1'b1) nd++;
    end
    check("abort/no_done", nd, 0);
    run("post_abort", 0, 0, 1, 0, 0, 100, 1'b0, 1'b0);

    for (int i = 0; i < 12; i++) begin
      rand_poly(c0, c1, c2, c3);
      y = int'($urandom_range(0, 4095)) - 2048;
      run($sformatf("rnd%0d", i), 0, c0, c1, c2, c3, y, 1'b0, i[0]);
    end
    for (int i = 0; i < 6; i++) begin
      rand_poly(c0, c1, c2, c3);
      y = int'($urandom_range(0, 600)) - 300;
      run($sformatf("srnd%0d", i), 1, c0, c1, c2, c3, y, 1'b0, 1'b0);
    end
    for (int i = 0; i < 3; i++) begin
      rand_poly(c0, c1, c2, c3);
      y = int'($urandom_range(0, 4095)) - 2048;
      run($sformatf("drnd%0d", i), 2, c0, c1, c2, c3, y, 1'b0, 1'b0);
    end

`ifdef POLY_INV_DESC_EN
    run("desc100", 0, 0, -1, 0, 0, -100, 1'b1, 1'b0);
    run("desc_asc", 0, 0, 1, 0, 0, 100, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      rand_poly(c0, c1, c2, c3);
      y = int'($urandom_range(0, 4095)) - 2048;
      run($sformatf("dsc%0d", i), 0, -c0, -c1, -c2, -c3, y,
          1'b1, 1'b0);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/poly_inverse.md
# poly_inverse

Inverse evaluator for the cubic polynomial datapath: given a 12-bit signed target `y_target` and coefficients p0..p3, finds the smallest signed 12-bit `x` in `[X_MIN, X_MAX]` with p(x) >= y_target, where p(x) = p0 + p1·x + p2·x² + p3·x³. It uses bisection over a polynomial that is non-decreasing on the search range. Each probe is evaluated by a sequential Horner engine with exact wide arithmetic. The block sits beside the forward polynomial pipeline and serves calibration and inversion requests, one at a time.

## Interface
- `X_MIN`, default -2048: lower bound of the search range, signed 12-bit.
- `X_MAX`, default 2047: upper bound of the search range, signed 12-bit. `X_MIN <= X_MAX` is required; the block stops elaboration (`$error`) otherwise.
- `clock`  in  1  sole clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request strobe; accepted only in IDLE.
- `y_target`  in  12  signed target value; captured on accept.
- `param_in0`..`param_in3`  in  12 each  signed coefficients p0..p3; captured on accept.
- `busy`  out  1  high from the cycle after accept through the done cycle.
- `done`  out  1  one-cycle completion pulse.
- `x_out`  out  12  signed result.
- `found`  out  1  p(x_out) == y_target exactly.
- `fail`  out  1  no x in range satisfies the condition.

## Operation
- Reset values: `busy`=0, `done`=0, `x_out`=0, `found`=0, `fail`=0. The state returns to IDLE.
- **Reset mid-operation:** aborts the request immediately. No `done` pulse is produced.
- **Capture on accept:** `start` while in IDLE captures `y_target` and the params, and sets lo=`X_MIN`, hi=`X_MAX`. `start` while busy is ignored.
- **Arithmetic:**
  - Horner accumulator is 48-bit signed. Operands are sign-extended.
  - Horner steps, one multiply per cycle: acc=p3; acc=acc·x+p2; acc=acc·x+p1; acc=acc·x+p0.
  - The result is exact, with no wrap or overflow at any step.
  - The comparison against the sign-extended `y_target` is exact.
- **CHECK state:** evaluate p(hi).
  - If p(hi) < y: `fail`=1, `x_out`=`X_MAX`, `found`=0, go to DONE.
  - Otherwise go to SEARCH.
- **SEARCH state:**
  - While lo < hi: mid = (lo+hi)>>>1, computed in 13-bit signed so the result is the floor.
  - If p(mid) >= y, set hi=mid; otherwise set lo=mid+1.
  - When lo == hi, go to FINAL.
- **FINAL state:** evaluate p(lo). Set `x_out`=lo, `found`=(p(lo)==y), `fail`=0.
- **DONE state:** one cycle. `done`=1, then return to IDLE.
- **Output hold:** `x_out`, `found` and `fail` hold their values until the next accept. At accept they clear to 0.
- **Non-monotonic p:** the result is whatever the bisection yields. It is deterministic, but no correctness is claimed.

## Timing
- Cycle 0 is the cycle in which `start` is sampled high in IDLE.
- Each evaluation takes exactly 3 cycles. The decision is registered on the edge ending the third cycle, so there is no extra decision cycle.
- `done` is high in cycle 3E+1 and `busy` is high in cycles 1..3E+1, where E is the number of evaluations.
- E = 1 on fail.
- E = 2 + N otherwise, where N is the number of SEARCH iterations. N lies between floor and ceil of log2(X_MAX−X_MIN+1).
- Default range: N = 12, E = 14, `done` in cycle 43. Fail: `done` in cycle 4. Degenerate range X_MIN==X_MAX: `done` in cycle 7.
- The next `start` is accepted in the cycle after `done` at the earliest.
- If `start` and `reset` are high together, reset wins.

## Configuration
- `POLY_INV_DESC_EN` defined:
  - Adds input `descending` (1 bit), captured on accept.
  - When `descending`=1, p is taken as non-increasing. The search finds the smallest x with p(x) <= y.
  - In that mode the CHECK fail condition becomes p(hi) > y, and the SEARCH test becomes p(mid) <= y.
  - When `descending`=0, behaviour is identical to the non-decreasing search above.
- `POLY_INV_DESC_EN` undefined: the port is absent and only the non-decreasing search exists.

## Test plan
- p1=1, others 0, y=100, default range -> `x_out`=100, `found`=1, `fail`=0, `done` in cycle 43, `busy` high for cycles 1..43.
- p3=1, others 0: y=27 -> `x_out`=3, `found`=1; y=30 -> `x_out`=4, `found`=0.
- p1=1, y=2047 -> `x_out`=2047, `found`=1. p0=5, others 0, y=-5 -> `x_out`=-2048, `found`=0.
- p1=1, y=-2048 -> `x_out`=-2048, `found`=1. p1=1, y=2047 with p0=-1 -> `fail`=1, `x_out`=2047, `done` in cycle 4.
- Assert `reset` in cycle 20 of a search -> all outputs 0 next cycle, no `done`. A following request completes normally. `start` pulses while busy -> ignored, result unchanged.
- `POLY_INV_DESC_EN` defined, p1=-1, y=-100, `descending`=1 -> `x_out`=100, `found`=1, `done` in cycle 43.
